// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared types and constants for the 1x3 router datapath.
//   ROUTER_DATA_W     : byte width carried through the router
//   ROUTER_FIFO_DEPTH : default entry count of each destination FIFO
//   ADDR_FIELD_W      : width of the destination-address field in a header
//   fifo_entry_t      : one stored FIFO entry (header flag plus data byte)
//   payload_len()     : payload length field of a header byte
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int ADDR_FIELD_W      = 2;

  typedef struct packed {
    logic       hdr;
    logic [7:0] data;
  } fifo_entry_t;

  // Header layout is {payload_len[5:0], dest_addr[1:0]}.
  function automatic logic [5:0] payload_len(input logic [7:0] header);
    return header[7:ADDR_FIELD_W];
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// -----------------------------------------------------------------------------
// router_fifo_mem
// DEPTH x (WIDTH+1) storage array: synchronous write, asynchronous read.
// Contents are not reset; the surrounding pointers decide what is valid.
//   clock   : write clock
//   wr_en   : write strobe, already qualified by the caller
//   wr_addr : write address
//   wr_data : {hdr, data} entry to store
//   rd_addr : read address
//   rd_data : entry at rd_addr, combinational
// -----------------------------------------------------------------------------
module router_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WIDTH:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [WIDTH:0] rd_data
);

  logic [WIDTH:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/router_fifo.sv
// -----------------------------------------------------------------------------
// router_fifo
// Per-destination output FIFO of the 1x3 router. Stores {lfd_state, data_in}
// entries and tracks how many bytes of the packet being drained are still to
// leave, so the output side and soft-reset timeout know when it is gone.
//   clock          : system clock, rising edge
//   reset          : synchronous active-high reset (wins over soft_reset)
//   soft_reset     : synchronous flush, same effect as reset
//   write_enb      : write request from the sync block
//   read_enb       : read request from the destination
//   lfd_state      : header flag stored with the entry
//   data_in        : byte from the register stage
//   data_out       : registered read data, holds between reads
//   data_out_valid : one-cycle pulse the cycle after an accepted read
//   hdr_out        : header flag of the byte on data_out
//   full / empty   : combinational occupancy flags from the pointers
//   pkt_count_zero : remaining-bytes counter is zero
// -----------------------------------------------------------------------------
module router_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = ROUTER_FIFO_DEPTH,
  parameter int WIDTH = ROUTER_DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_out_valid,
  output logic             hdr_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_count_zero
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]    wr_ptr_r;
  logic [AW:0]    rd_ptr_r;
  logic [6:0]     remain_cnt_r;
  logic           wr_accept_s;
  logic           rd_accept_s;
  logic [WIDTH:0] wr_entry_s;
  logic [WIDTH:0] rd_entry_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pkt_count_zero = (remain_cnt_r == 7'd0);
  assign wr_entry_s = {lfd_state, data_in};

  // Accept qualifiers; flags use start-of-cycle pointers, so a write into an
  // empty FIFO cannot be read in the same cycle.
  always_comb begin
    wr_accept_s = 1'b0;
    rd_accept_s = 1'b0;
    if (reset || soft_reset) begin
      wr_accept_s = 1'b0;
      rd_accept_s = 1'b0;
    end else begin
      wr_accept_s = write_enb && !full;
      rd_accept_s = read_enb && !empty;
    end
  end

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_accept_s),
    .wr_addr (wr_ptr_r[AW-1:0]),
    .wr_data (wr_entry_s),
    .rd_addr (rd_ptr_r[AW-1:0]),
    .rd_data (rd_entry_s)
  );

  // Write and read pointer update.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (rd_accept_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

  // Registered read port; data_out holds when no read is accepted.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      data_out       <= '0;
      hdr_out        <= 1'b0;
      data_out_valid <= 1'b0;
    end else if (rd_accept_s) begin
      data_out       <= rd_entry_s[WIDTH-1:0];
      hdr_out        <= rd_entry_s[WIDTH];
      data_out_valid <= 1'b1;
    end else begin
      data_out_valid <= 1'b0;
    end
  end

  // Remaining-bytes counter: a header loads payload plus parity, every other
  // byte counts down and the count stops at zero.
  always_ff @(posedge clock) begin
    if (reset || soft_reset) begin
      remain_cnt_r <= 7'd0;
    end else if (rd_accept_s && rd_entry_s[WIDTH]) begin
      remain_cnt_r <= {1'b0, payload_len(rd_entry_s[7:0])} + 7'd1;
    end else if (rd_accept_s && (remain_cnt_r != 7'd0)) begin
      remain_cnt_r <= remain_cnt_r - 7'd1;
    end else begin
      remain_cnt_r <= remain_cnt_r;
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       hdr_out;
  logic       full;
  logic       empty;
  logic       pkt_count_zero;

  int checks = 0;
  int errors = 0;

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .soft_reset     (soft_reset),
    .write_enb      (write_enb),
    .read_enb       (read_enb),
    .lfd_state      (lfd_state),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .hdr_out        (hdr_out),
    .full           (full),
    .empty          (empty),
    .pkt_count_zero (pkt_count_zero)
  );

  always #5 clock = ~clock;

  // One clock with the given requests; outputs are settled on return.
  task automatic step(input logic we, input logic re, input logic lfd, input logic [7:0] din);
    write_enb = we;
    read_enb  = re;
    lfd_state = lfd;
    data_in   = din;
    @(posedge clock);
    #1;
    write_enb = 1'b0;
    read_enb  = 1'b0;
    lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 8'h77);
    reset = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full);
    end
    checks++;
    if (data_out !== 8'h00 || data_out_valid !== 1'b0 || hdr_out !== 1'b0) begin
      errors++; $display("FAIL reset_out got data=%h valid=%b hdr=%b exp 00/0/0", data_out, data_out_valid, hdr_out);
    end
    checks++;
    if (pkt_count_zero !== 1'b1) begin
      errors++; $display("FAIL reset_pcz got %b exp 1", pkt_count_zero);
    end
  endtask

  task automatic test_packet();
    logic [7:0] pkt [5];
    logic       pcz_exp [5];
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h0D;
    // counter after each read: 4,3,2,1,0
    pcz_exp[0] = 1'b0; pcz_exp[1] = 1'b0; pcz_exp[2] = 1'b0; pcz_exp[3] = 1'b0; pcz_exp[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, (i == 0), pkt[i]);
      if (i == 0) begin
        checks++;
        if (empty !== 1'b0) begin
          errors++; $display("FAIL pkt_first_write_empty got %b exp 0", empty);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (data_out !== pkt[i] || data_out_valid !== 1'b1) begin
        errors++; $display("FAIL pkt_data[%0d] got %h valid=%b exp %h valid=1", i, data_out, data_out_valid, pkt[i]);
      end
      checks++;
      if (hdr_out !== (i == 0)) begin
        errors++; $display("FAIL pkt_hdr[%0d] got %b exp %b", i, hdr_out, (i == 0));
      end
      checks++;
      if (pkt_count_zero !== pcz_exp[i]) begin
        errors++; $display("FAIL pkt_pcz[%0d] got %b exp %b", i, pkt_count_zero, pcz_exp[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (empty !== 1'b1 || data_out_valid !== 1'b0) begin
      errors++; $display("FAIL pkt_end got empty=%b valid=%b exp empty=1 valid=0", empty, data_out_valid);
    end
  endtask

  task automatic test_full_and_rw();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      if (i == 14) begin
        checks++;
        if (full !== 1'b0) begin
          errors++; $display("FAIL full_early got %b exp 0 after 15 writes", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL full_set got full=%b empty=%b exp full=1 empty=0", full, empty);
    end
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    checks++;
    if (full !== 1'b1) begin
      errors++; $display("FAIL full_drop got full=%b exp 1", full);
    end
    // simultaneous read and write while full: read wins, 0xAA dropped
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    checks++;
    if (data_out !== 8'h00 || data_out_valid !== 1'b1) begin
      errors++; $display("FAIL full_rw_data got %h valid=%b exp 00 valid=1", data_out, data_out_valid);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++; $display("FAIL full_rw_occ got full=%b exp 0 (15 entries)", full);
    end
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (data_out !== 8'(i) || data_out_valid !== 1'b1) begin
        errors++; $display("FAIL full_drain[%0d] got %h valid=%b exp %h", i, data_out, data_out_valid, 8'(i));
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL full_drain_empty got %b exp 1", empty);
    end
    checks++;
    if (pkt_count_zero !== 1'b1) begin
      errors++; $display("FAIL full_drain_pcz got %b exp 1", pkt_count_zero);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] tail [5];
    tail[0] = 8'h03; tail[1] = 8'h04; tail[2] = 8'h05; tail[3] = 8'h55; tail[4] = 8'h66;
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
    end
    step(1'b1, 1'b1, 1'b0, 8'h55);
    checks++;
    if (data_out !== 8'h01 || empty !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL b2b_rw0 got %h empty=%b full=%b exp 01 0 0", data_out, empty, full);
    end
    step(1'b1, 1'b1, 1'b0, 8'h66);
    checks++;
    if (data_out !== 8'h02 || empty !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL b2b_rw1 got %h empty=%b full=%b exp 02 0 0", data_out, empty, full);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      checks++;
      if (data_out !== tail[i] || data_out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_drain[%0d] got %h valid=%b exp %h", i, data_out, data_out_valid, tail[i]);
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++; $display("FAIL b2b_empty got %b exp 1", empty);
    end
  endtask

  task automatic test_soft_reset();
    step(1'b1, 1'b0, 1'b1, 8'h0D);
    step(1'b1, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b0, 8'h22);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (data_out !== 8'h0D || pkt_count_zero !== 1'b0) begin
      errors++; $display("FAIL srst_pre got %h pcz=%b exp 0D pcz=0", data_out, pkt_count_zero);
    end
    soft_reset = 1'b1;
    step(1'b1, 1'b0, 1'b0, 8'h99);
    soft_reset = 1'b0;
    checks++;
    if (empty !== 1'b1 || data_out !== 8'h00 || pkt_count_zero !== 1'b1 || hdr_out !== 1'b0) begin
      errors++; $display("FAIL srst_state got empty=%b data=%h pcz=%b hdr=%b exp 1 00 1 0", empty, data_out, pkt_count_zero, hdr_out);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (empty !== 1'b1 || data_out_valid !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL srst_write_dropped got empty=%b valid=%b data=%h exp 1 0 00", empty, data_out_valid, data_out);
    end
  endtask

  task automatic test_empty_read();
    step(1'b1, 1'b0, 1'b0, 8'h33);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (data_out !== 8'h33 || data_out_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL empty_read got %h valid=%b empty=%b exp 33 0 1", data_out, data_out_valid, empty);
    end
    // write and read together on empty: write only, no fall-through
    step(1'b1, 1'b1, 1'b0, 8'h44);
    checks++;
    if (data_out_valid !== 1'b0 || data_out !== 8'h33 || empty !== 1'b0) begin
      errors++; $display("FAIL no_fallthrough got valid=%b data=%h empty=%b exp 0 33 0", data_out_valid, data_out, empty);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    checks++;
    if (data_out !== 8'h44 || data_out_valid !== 1'b1 || empty !== 1'b1) begin
      errors++; $display("FAIL empty_ptrs got %h valid=%b empty=%b exp 44 1 1", data_out, data_out_valid, empty);
    end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_full_and_rw();
    test_back_to_back();
    test_soft_reset();
    test_empty_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- Per-destination output FIFO of the 1x3 router; three instances sit directly downstream of the register stage.
- Accepts the register stage's byte stream (header, payload, parity) and tags each entry with a header flag taken from the load-first-data state.
- Tracks the packet currently being drained so that the output side and the soft-reset timeout logic know when a packet has fully left.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, minimum 4.
- WIDTH, 8, data byte width; the stored entry is WIDTH+1 bits wide (header flag plus data).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- soft_reset  in  1  synchronous flush from the sync block's read-timeout; same effect as reset.
- write_enb  in  1  write request from the sync block.
- read_enb  in  1  read request from the destination.
- lfd_state  in  1  high while the header byte is presented; stored as the entry's header flag.
- data_in  in  WIDTH  byte from the register stage.
- data_out  out  WIDTH  registered read data.
- data_out_valid  out  1  high for exactly one cycle, the cycle after an accepted read.
- hdr_out  out  1  header flag of the byte on data_out; qualified by data_out_valid.
- full  out  1  combinational from the pointers: all DEPTH entries are occupied.
- empty  out  1  combinational from the pointers: no entries are occupied.
- pkt_count_zero  out  1  high when the remaining-bytes counter is 0.

Behaviour:
- Reset and soft_reset values:
  - Write and read pointers = 0, so empty=1 and full=0.
  - data_out=0, data_out_valid=0, hdr_out=0.
  - Remaining-bytes counter = 0, so pkt_count_zero=1.
  - Storage contents are don't-care.
  - reset has priority over soft_reset.
  - While either is high, all writes and reads in that cycle are dropped.
- Pointers: each is log2(DEPTH)+1 bits wide.
  - empty when the two pointers are equal.
  - full when the MSBs differ and the lower bits are equal.
  - Both pointers wrap naturally.
- Write: accepted when write_enb=1 and full=0.
  - Stores {lfd_state, data_in} at the write pointer, then increments the write pointer.
  - A write request while full is silently dropped; the pointer does not move.
- Read: accepted when read_enb=1 and empty=0.
  - The entry at the read pointer is registered to {hdr_out, data_out} and data_out_valid=1 on the next cycle.
  - The read pointer then increments.
  - A read request while empty is ignored: data_out holds its value and data_out_valid=0.
- Latency:
  - A write at cycle N clears empty at N+1.
  - A read at N presents its data at N+1.
  - No fall-through: a write into an empty FIFO and a read in the same cycle results in the write being accepted and the read ignored.
- Simultaneous read and write:
  - When neither full nor empty, both are accepted and the occupancy is unchanged.
  - When full, the read is accepted and the write is dropped, because full is evaluated from the start-of-cycle pointers.
- Remaining-bytes counter (7 bits):
  - On an accepted read of a header-flagged entry, load payload_len + 1, where payload_len = data[7:2]; this counts the payload plus the parity byte.
  - On an accepted read of a non-header entry with counter > 0, decrement by 1.
  - The counter saturates at 0 and never underflows.
- data_out holds between reads; it is never tristated.

Decomposition:
- router_pkg holds:
  - ROUTER_DATA_W = 8 and ROUTER_FIFO_DEPTH = 16.
  - Packed struct fifo_entry_t {logic hdr; logic [7:0] data;}.
  - Function payload_len(header) returning header[7:2].
  - Constant ADDR_FIELD_W = 2.
- One sub-module, router_fifo_mem: a synchronous-write, asynchronous-read DEPTH x (WIDTH+1) array.
- Pointer, flag and counter logic stay in router_fifo.

Test Plan:
- Reset, then write header 0x0D (lfd_state=1, payload_len=3), bytes 0x11, 0x22, 0x33 and parity 0x0D^0x11^0x22^0x33 = 0x0D; then read 5 times.
  - Expected: data_out sequence 0x0D, 0x11, 0x22, 0x33, 0x0D.
  - hdr_out=1 only on the first byte.
  - Counter sequence 4, 3, 2, 1, 0; pkt_count_zero=1 after the 5th read; empty=1.
- Write 16 bytes 0x00..0x0F with no reads.
  - Expected: full=1 after the 16th write.
  - A 17th write of 0xFF is dropped; draining returns 0x00..0x0F in order, then empty=1.
- With the FIFO full, assert read_enb and write_enb (data 0xAA) together.
  - Expected: 0x00 is read, 0xAA is not stored, and occupancy drops to 15.
- With 5 entries stored, read 2 while writing 0x55 and 0x66 in the same two cycles, then drain.
  - Expected: occupancy stays 5 throughout, the pointers wrap correctly, and 0x55 and 0x66 come out last.
- Write 3 bytes, assert soft_reset for one cycle together with write_enb.
  - Expected: empty=1, data_out=0, pkt_count_zero=1, and the concurrent write is dropped.
- On an empty FIFO, assert read_enb with data_out=0x33.
  - Expected: data_out stays 0x33, data_out_valid=0, and the pointers are unchanged.
